aurora_tx_arbiter: RTL
======================

# aurora_tx_arbiter

Round-robin frame scheduler that shares the single Aurora TX AXI4-Stream user port between NUM_SRC fixed-length frame sources. It grants one source at a time, streams exactly FRAME_WORDS words from it through a registered output stage that honours m_tready backpressure, and asserts tlast on the final word. It sits between the per-channel data formatters and the Aurora core TX user interface.

## Interface

Parameters:
- NUM_SRC, 3, number of requesting sources (2..8)
- FRAME_WORDS, 3, words per frame (1..255)
- DATA_W, 32, word width; tkeep width = DATA_W/8

Ports (GW = max(1, clog2(NUM_SRC))):
- clk  in  1  single clock for all logic
- reset  in  1  asynchronous, active-low reset; asserted at 0, released synchronously to clk
- en  in  1  arbitration enable; low blocks new grants only
- src_req  in  NUM_SRC  per-source level request: frame ready
- src_data  in  NUM_SRC*DATA_W  source i current word at bits [i*DATA_W +: DATA_W]
- src_pop  out  NUM_SRC  one-hot, combinational; high in the cycle the output register captures the granted source's current word
- m_tdata  out  DATA_W  stream data (registered)
- m_tvalid  out  1  stream valid (registered)
- m_tlast  out  1  final word of frame (registered)
- m_tkeep  out  DATA_W/8  all ones when m_tvalid, else zero
- m_tready  in  1  downstream ready
- grant_id  out  GW  index of source currently or last granted
- busy  out  1  high while in SEND
- frame_cnt  out  16  completed frames, wraps 0xFFFF -> 0

## Operation

- States: IDLE, SEND. Registered state; no other states.
- Reset (reset=0): state=IDLE, m_tdata=0, m_tvalid=0, m_tlast=0, m_tkeep=0, grant_id=0, busy=0, frame_cnt=0, rr pointer=0, word counter=0. src_pop=0 while in reset.
- IDLE: m_tvalid=0. If en=1 and any src_req bit set: winner = first set bit scanning ptr, ptr+1, ..., wrapping modulo NUM_SRC. In that cycle src_pop[winner]=1; at the edge: grant_id<=winner, m_tdata<=src_data[winner], m_tvalid<=1, m_tlast<=(FRAME_WORDS==1), wcnt<=1, state<=SEND.
- SEND, m_tvalid=1 and m_tready=0: all outputs hold; src_pop=0.
- SEND, handshake (m_tvalid & m_tready) with m_tlast=0: src_pop[grant_id]=1; m_tdata<=next word, m_tlast<=(wcnt==FRAME_WORDS-1), wcnt<=wcnt+1.
- SEND, handshake with m_tlast=1: src_pop=0; m_tvalid<=0, m_tlast<=0, frame_cnt<=frame_cnt+1, ptr<=(grant_id+1) mod NUM_SRC, state<=IDLE.
- Granted frame always completes: src_req and en are ignored during SEND; source must keep src_data valid until its final pop.
- Exactly FRAME_WORDS pops per granted frame; pop count equals word count accepted downstream.
- Data values are passed unmodified; zero words are transmitted as valid.
- Reset asserted mid-frame: frame abandoned immediately, all outputs to reset values; no partial tlast emitted.

## Timing

- Grant latency: src_req seen in IDLE at edge k -> first word with m_tvalid=1 after edge k.
- With m_tready held 1: a frame occupies FRAME_WORDS consecutive valid cycles, followed by exactly one idle (IDLE) cycle before the next frame; throughput FRAME_WORDS/(FRAME_WORDS+1).
- m_tvalid never drops while m_tready=0 within a frame; m_tdata/m_tlast stable until handshake.
- src_pop is combinational from state, m_tvalid, m_tready, wcnt; no path from src_data.
- frame_cnt, ptr update on the edge accepting the tlast word.

## Test plan

- Single source: NUM_SRC=3, src_req=3'b001, words A1,A2,A3, m_tready=1 -> m_tdata A1,A2,A3 on 3 consecutive cycles, m_tlast only on A3, src_pop[0] three pulses, frame_cnt=1.
- Fairness: src_req=3'b111 held for 4 frames -> grant_id sequence 0,1,2,0, one idle cycle between frames, frame_cnt=4.
- Backpressure: m_tready=0 for 5 cycles after first word -> m_tdata stays A1, m_tvalid=1, no src_pop; on release frame completes with 3 pops total.
- Enable gating: en=0 with src_req=3'b010 -> m_tvalid stays 0; en dropped mid-frame -> current frame still completes, then no new grant.
- Reset mid-frame: reset=0 after second word -> next cycle m_tvalid=0, m_tlast=0, frame_cnt=0, grant_id=0; after release src_req=3'b100 granted normally.
- Counter wrap: force 65536 frames (or preload via bench) -> frame_cnt wraps 0xFFFF -> 0x0000 on tlast handshake.

Source files
------------

// File: rtl/aurora_tx_arbiter.sv
// Round-robin frame scheduler feeding the Aurora TX AXI4-Stream user port.
// Streams FRAME_WORDS words per grant through a registered, backpressure-aware output stage.
module aurora_tx_arbiter #(
  parameter int unsigned NUM_SRC     = 3,
  parameter int unsigned FRAME_WORDS = 3,
  parameter int unsigned DATA_W      = 32,
  localparam int unsigned GW         = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  localparam int unsigned KW         = DATA_W / 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic [NUM_SRC-1:0]        src_req,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic [NUM_SRC-1:0]        src_pop,
  output logic [DATA_W-1:0]         m_tdata,
  output logic                      m_tvalid,
  output logic                      m_tlast,
  output logic [KW-1:0]             m_tkeep,
  input  logic                      m_tready,
  output logic [GW-1:0]             grant_id,
  output logic                      busy,
  output logic [15:0]               frame_cnt
);

  localparam int unsigned CW = 8;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       wcnt, wcnt_nxt;
  logic [GW-1:0]       ptr, ptr_nxt, grant_nxt, winner;
  logic [DATA_W-1:0]   data_nxt;
  logic                valid_nxt, last_nxt;
  logic [15:0]         cnt_nxt;
  logic [NUM_SRC-1:0]  pop_c;
  logic [DATA_W-1:0]   words [NUM_SRC];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_words
    assign words[i] = src_data[i*DATA_W +: DATA_W];
  end

  // First requesting source scanning upward from ptr; lower offsets overwrite later.
  always_comb begin
    int idx;
    winner = ptr;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= int'(NUM_SRC)) idx = idx - int'(NUM_SRC);
      if (src_req[GW'(idx)]) winner = GW'(idx);
    end
  end

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    ptr_nxt   = ptr;
    grant_nxt = grant_id;
    data_nxt  = m_tdata;
    valid_nxt = m_tvalid;
    last_nxt  = m_tlast;
    cnt_nxt   = frame_cnt;
    pop_c     = '0;
    case (state)
      IDLE: begin
        valid_nxt = 1'b0;
        last_nxt  = 1'b0;
        if (en && (|src_req)) begin
          pop_c[winner] = 1'b1;
          grant_nxt     = winner;
          data_nxt      = words[winner];
          valid_nxt     = 1'b1;
          last_nxt      = (FRAME_WORDS == 1);
          wcnt_nxt      = CW'(1);
          state_nxt     = SEND;
        end
      end
      SEND: begin
        if (m_tvalid && m_tready) begin
          if (!m_tlast) begin
            pop_c[grant_id] = 1'b1;
            data_nxt        = words[grant_id];
            last_nxt        = (wcnt == CW'(FRAME_WORDS - 1));
            wcnt_nxt        = wcnt + CW'(1);
          end else begin
            valid_nxt = 1'b0;
            last_nxt  = 1'b0;
            cnt_nxt   = frame_cnt + 16'd1;
            ptr_nxt   = (grant_id == GW'(NUM_SRC - 1)) ? '0 : grant_id + GW'(1);
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pops are suppressed while reset is held so sources never advance during reset.
  assign src_pop = reset ? pop_c : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wcnt      <= '0;
      ptr       <= '0;
      grant_id  <= '0;
      m_tdata   <= '0;
      m_tvalid  <= 1'b0;
      m_tlast   <= 1'b0;
      m_tkeep   <= '0;
      busy      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state     <= state_nxt;
      wcnt      <= wcnt_nxt;
      ptr       <= ptr_nxt;
      grant_id  <= grant_nxt;
      m_tdata   <= data_nxt;
      m_tvalid  <= valid_nxt;
      m_tlast   <= last_nxt;
      m_tkeep   <= valid_nxt ? '1 : '0;
      busy      <= (state_nxt == SEND);
      frame_cnt <= cnt_nxt;
    end
  end

endmodule
